// File: rtl/add_pipe_pkg.sv
// add_pipe_pkg: shared adder width, latency and FIFO result record for the adder wrapper.
// ADD_PIPE_SEQ_TAG_EN adds an 8-bit issue tag to each stored result.
package add_pipe_pkg;
    localparam int ADD_WIDTH = 32;
    localparam int ADD_LAT = 4;

    typedef struct packed {
`ifdef ADD_PIPE_SEQ_TAG_EN
        logic [7:0] tag;
`endif
        logic cout;
        logic [ADD_WIDTH-1:0] sum;
    } add_res_t;
endpackage

// File: rtl/add_res_fifo.sv
// add_res_fifo: synchronous result FIFO with occupancy count and async active-low reset.
module add_res_fifo
    import add_pipe_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  add_res_t din,
    input  logic pop,
    output add_res_t dout,
    output logic [CW-1:0] count
);
    add_res_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= din;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count <= count + CW'(push) - CW'(pop);
        end

    // Head entry is only rewritten when full with a concurrent pop, so it holds while stalled
    assign dout = mem[rd_ptr];

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && count == CW'(DEPTH)))
        else $error("add_res_fifo: push while full");
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && count == '0))
        else $error("add_res_fifo: pop while empty");
`endif
endmodule

// File: rtl/add_pipe_issue_ctrl.sv
// add_pipe_issue_ctrl: credit-based valid/ready wrapper around the 4-stage pipelined adder.
// ADD_PIPE_SEQ_TAG_EN adds out_tag, an 8-bit issue sequence number carried with each result.
module add_pipe_issue_ctrl
    import add_pipe_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH,
    parameter int LAT = ADD_LAT,
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic in_cin,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic add_cout,
    output logic out_valid,
    input  logic out_ready,
    output logic [WIDTH-1:0] out_sum,
`ifdef ADD_PIPE_SEQ_TAG_EN
    output logic [7:0] out_tag,
`endif
    output logic out_cout
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [LAT-1:0] vld_sr;
    logic [CW-1:0] inflight, fifo_count;
    logic [CW:0] used;
    logic fire, push, pop;
    add_res_t wr_res, rd_res;

    // Credits cover both in-flight ops and stored results, so a push always has room
    assign used = {1'b0, inflight} + {1'b0, fifo_count};
    assign in_ready = used < (CW+1)'(DEPTH);
    assign fire = in_valid & in_ready;
    assign add_a = fire ? in_a : '0;
    assign add_b = fire ? in_b : '0;
    assign add_cin = fire & in_cin;
    assign push = vld_sr[LAT-1];
    assign out_valid = fifo_count != '0;
    assign pop = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            vld_sr <= '0;
            inflight <= '0;
        end else begin
            vld_sr <= {vld_sr[LAT-2:0], fire};
            inflight <= inflight + CW'(fire) - CW'(vld_sr[LAT-1]);
        end

    assign wr_res.sum = add_sum;
    assign wr_res.cout = add_cout;

`ifdef ADD_PIPE_SEQ_TAG_EN
    logic [7:0] seq;
    logic [LAT-1:0][7:0] tag_sr;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            seq <= '0;
            tag_sr <= '0;
        end else begin
            seq <= seq + 8'(fire);
            tag_sr <= {tag_sr[LAT-2:0], seq};
        end

    assign wr_res.tag = tag_sr[LAT-1];
    assign out_tag = rd_res.tag;
`endif

    add_res_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(push),
        .din(wr_res),
        .pop(pop),
        .dout(rd_res),
        .count(fifo_count)
    );

    assign out_sum = rd_res.sum;
    assign out_cout = rd_res.cout;
endmodule

// File: doc/add_pipe_issue_ctrl.md
Name: add_pipe_issue_ctrl

Overview:
- Flow-control wrapper placed directly around the team's 4-stage, 8-bit-sliced 32-bit pipelined adder.
- Upstream side: accepts operand triples (a, b, cin) over a valid/ready handshake and drives the adder inputs.
- Tracking: the adder has no valid or stall path, so this block tracks in-flight operations with a latency-matched valid shift register.
- Downstream side: captures each {cout, sum} into a result FIFO presented on a valid/ready handshake. Credit-based issue guarantees a result is never dropped.

Parameters:
- WIDTH, 32, operand/sum width; must equal the adder width.
- LAT, 4, adder latency in clock edges from input capture to sum/cout valid.
- DEPTH, 8, result FIFO entries; legal range is LAT to 64, power of two.

Ports:
- clk  in  1  rising-edge clock, shared with the adder.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand triple valid.
- in_ready  out  1  block can accept a triple this cycle.
- in_a  in  WIDTH  operand a.
- in_b  in  WIDTH  operand b.
- in_cin  in  1  carry in.
- add_a  out  WIDTH  to adder a.
- add_b  out  WIDTH  to adder b.
- add_cin  out  1  to adder cin.
- add_sum  in  WIDTH  from adder sum.
- add_cout  in  1  from adder cout.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_sum  out  WIDTH  result sum.
- out_cout  out  1  result carry out.

Behaviour:
- Reset:
  - Single clock clk; reset rst_n is asynchronous, active-low.
  - Asserting rst_n clears the valid shift register, in-flight count, FIFO pointers and count. This forces out_valid=0 and in_ready=1 (DEPTH>0).
  - Operations in flight at reset are discarded. Adder outputs emerging afterwards are ignored because their shift-register bits are cleared.
- Issue:
  - fire = in_valid & in_ready.
  - add_a/add_b/add_cin are combinational copies of in_a/in_b/in_cin, gated to 0 when fire=0 (low toggle).
  - in_ready = (inflight + fifo_count) < DEPTH, evaluated from registered state only; no combinational dependence on out_ready.
- Tracking:
  - vld_sr[LAT-1:0] <= {vld_sr[LAT-2:0], fire} each edge.
  - When vld_sr[LAT-1]=1, add_sum/add_cout belong to the op issued LAT edges earlier and are pushed into the FIFO in that cycle.
- Counts:
  - inflight = popcount(vld_sr), or an equivalent counter: +fire, -vld_sr[LAT-1].
  - fifo_count: +push, -pop, where pop = out_valid & out_ready.
  - Simultaneous push and pop leave the count unchanged and are legal at full and at empty.
- Output:
  - out_valid = fifo_count != 0.
  - out_sum/out_cout come from the FIFO head register. They must hold stable while out_valid & !out_ready.
- Throughput and latency:
  - Sustained one op per cycle when out_ready is held 1.
  - Minimum latency from fire to out_valid: LAT+1 edges (one FIFO write edge).
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally; fifo_count is log2(DEPTH)+1 bits.
- Overflow:
  - The credit rule makes overflow impossible.
  - An assertion (simulation only) fires if push occurs with fifo_count==DEPTH, or pop occurs with fifo_count==0.

Optional Feature:
- Macro: ADD_PIPE_SEQ_TAG_EN.
- Enabled:
  - Adds output port out_tag [7:0].
  - An 8-bit issue counter increments on each fire and wraps 255->0.
  - The tag travels in a LAT-deep tag shift register alongside vld_sr and is stored in the FIFO with the result.
  - Reset clears the counter to 0.
- Disabled: no port, counter or storage; behaviour is otherwise identical.

Decomposition:
- Package add_pipe_pkg holds:
  - localparams ADD_WIDTH=32 and ADD_LAT=4.
  - typedef add_res_t = struct {cout, sum[ADD_WIDTH-1:0]}, plus a tag field under ADD_PIPE_SEQ_TAG_EN.
- Sub-module add_res_fifo: synchronous FIFO of add_res_t, DEPTH entries, count output, async active-low reset.
- Top level contains the valid/tag shift registers, credit logic and handshake glue.

Test Plan:
- Single op after reset: a=0x0000_00FF, b=0x0000_0001, cin=0 -> out_valid after 5 edges with out_sum=0x0000_0100, out_cout=0.
- Carry across all slices: a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> out_sum=0x0000_0000, out_cout=1.
- Streaming: 100 back-to-back random ops with out_ready=1 -> in_ready never drops, results arrive in order and match a reference model.
- Backpressure to full: out_ready=0, send 10 ops with DEPTH=8 -> exactly 8 accepted, in_ready=0 thereafter. The held head is the first op, stable. Raising out_ready drains all 8 in order and in_ready reasserts.
- Reset mid-flight: issue 3 ops, assert rst_n low at edge 2 -> out_valid stays 0 and no stale results appear after release. A new op a=5, b=7 -> out_sum=12.
- ADD_PIPE_SEQ_TAG_EN: issue 260 ops -> tags run 0..255,0..3 in order.
